ub_sequencer: RTL and testbench

UB_SEQUENCER -- requirements
Module: ub_sequencer

---
 rtl/ub_sequencer.sv | 144 ++++++++++++++
 tb/tb_ub_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_sequencer.sv
// Unified-buffer sequencer: walks a job of tiles through load, accumulator wait and store.
// Moore FSM with every output registered; abort and reset cancel a job without a done pulse.
module ub_sequencer #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned UB_DEPTH   = 64,
  parameter int unsigned TILE_WORDS = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [3:0]        num_tiles,
  input  logic              acc1_full,
  input  logic              acc2_full,
  output logic [ADDR_W-1:0] ub_addr,
  output logic              ub_load_input,
  output logic              ub_store,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        tile_idx
);

  typedef enum logic [2:0] {StIdle, StLoad, StWaitAcc, StStore, StDone} state_e;

  localparam int unsigned RangeW = ADDR_W + 2;
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] in_base_q;
  logic [ADDR_W-1:0] out_base_q;
  logic [3:0]        num_q;
  logic [7:0]        wait_cnt_q;

  logic [RangeW-1:0] span;
  logic [RangeW-1:0] in_end;
  logic [RangeW-1:0] out_end;
  logic              range_ok;

  // Range check is done two bits wider than the address so a wrap cannot pass.
  always_comb begin
    span     = RangeW'(TILE_WORDS) * RangeW'(num_tiles);
    in_end   = RangeW'(in_base) + span;
    out_end  = RangeW'(out_base) + span;
    range_ok = (in_end <= RangeW'(UB_DEPTH)) && (out_end <= RangeW'(UB_DEPTH));
  end

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [3:0]        idx);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(TILE_WORDS) * ADDR_W'(idx);
    return base + off;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      in_base_q     <= '0;
      out_base_q    <= '0;
      num_q         <= '0;
      wait_cnt_q    <= '0;
      ub_addr       <= '0;
      ub_load_input <= 1'b0;
      ub_store      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      tile_idx      <= '0;
    end else if (abort) begin
      // err and tile_idx deliberately keep their values.
      state_q       <= StIdle;
      ub_load_input <= 1'b0;
      ub_store      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            if (!range_ok) begin
              err <= 1'b1;
            end else begin
              err        <= 1'b0;
              busy       <= 1'b1;
              in_base_q  <= in_base;
              out_base_q <= out_base;
              num_q      <= num_tiles;
              tile_idx   <= '0;
              if (num_tiles == 4'd0) begin
                state_q <= StDone;
                done    <= 1'b1;
              end else begin
                state_q       <= StLoad;
                ub_load_input <= 1'b1;
                ub_addr       <= in_base;
              end
            end
          end
        end
        StLoad: begin
          ub_load_input <= 1'b0;
          wait_cnt_q    <= '0;
          state_q       <= StWaitAcc;
        end
        StWaitAcc: begin
          if (acc1_full && acc2_full) begin
            state_q  <= StStore;
            ub_store <= 1'b1;
            ub_addr  <= tile_addr(out_base_q, tile_idx);
          end else if (wait_cnt_q == TimeoutLast) begin
            state_q <= StIdle;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StStore: begin
          ub_store <= 1'b0;
          if (tile_idx == num_q - 4'd1) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            tile_idx      <= tile_idx + 4'd1;
            state_q       <= StLoad;
            ub_load_input <= 1'b1;
            ub_addr       <= tile_addr(in_base_q, tile_idx + 4'd1);
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ub_sequencer.sv
// Directed bench for ub_sequencer: cycle-exact checks of each scenario with hand-derived values.
module tb_ub_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, acc1_full, acc2_full;
  logic [12:0] in_base, out_base, ub_addr;
  logic [3:0]  num_tiles, tile_idx;
  logic        ub_load_input, ub_store, busy, done, err;

  int n_vec = 0;
  int n_bad = 0;

  logic [12:0] load_q[$];
  logic [12:0] store_q[$];
  int          done_cnt = 0;
  int          overlap_cnt = 0;

  ub_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .in_base      (in_base),
    .out_base     (out_base),
    .num_tiles    (num_tiles),
    .acc1_full    (acc1_full),
    .acc2_full    (acc2_full),
    .ub_addr      (ub_addr),
    .ub_load_input(ub_load_input),
    .ub_store     (ub_store),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .tile_idx     (tile_idx)
  );

  always #5 clk = ~clk;

  // Event log, sampled mid-cycle.
  always @(negedge clk) begin
    if (ub_load_input === 1'b1) load_q.push_back(ub_addr);
    if (ub_store === 1'b1) store_q.push_back(ub_addr);
    if (done === 1'b1) done_cnt++;
    if (ub_load_input === 1'b1 && ub_store === 1'b1) overlap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b1; acc1_full = 1'b1; acc2_full = 1'b1;
    in_base = 13'd0; out_base = 13'd0; num_tiles = 4'd1;
    repeat (3) tick();
    n_vec++; if (ub_addr !== 13'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", ub_addr); end
    n_vec++; if (ub_load_input !== 1'b0) begin n_bad++; $display("FAIL rst_load: got %b want 0", ub_load_input); end
    n_vec++; if (ub_store !== 1'b0) begin n_bad++; $display("FAIL rst_store: got %b want 0", ub_store); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_vec++; if (tile_idx !== 4'd0) begin n_bad++; $display("FAIL rst_tile: got %0d want 0", tile_idx); end
    start = 1'b0; abort = 1'b0; acc1_full = 1'b0; acc2_full = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_two_tiles();
    int ld0 = load_q.size();
    int st0 = store_q.size();
    int dn0 = done_cnt;
    in_base = 13'd0; out_base = 13'd16; num_tiles = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (ub_load_input !== 1'b1 || ub_addr !== 13'd0) begin
      n_bad++; $display("FAIL basic_load0: got load=%b addr=%0d want load=1 addr=0", ub_load_input, ub_addr); end
    n_vec++; if (busy !== 1'b1 || tile_idx !== 4'd0) begin
      n_bad++; $display("FAIL basic_busy: got busy=%b tile=%0d want 1/0", busy, tile_idx); end
    for (int t = 0; t < 2; t++) begin
      repeat (3) tick();
      acc1_full = 1'b1; acc2_full = 1'b1;
      tick();
      acc1_full = 1'b0; acc2_full = 1'b0;
      n_vec++; if (ub_store !== 1'b1 || ub_addr !== 13'(16 + 4 * t)) begin
        n_bad++; $display("FAIL basic_store%0d: got st=%b addr=%0d want 1/%0d", t, ub_store, ub_addr, 16 + 4 * t); end
      tick();
    end
    n_vec++; if (done !== 1'b1 || tile_idx !== 4'd1) begin
      n_bad++; $display("FAIL basic_done: got done=%b tile=%0d want 1/1", done, tile_idx); end
    tick();
    n_vec++; if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL basic_end: got done=%b busy=%b err=%b want 0/0/0", done, busy, err); end
    n_vec++; if (load_q.size() - ld0 != 2 || load_q[ld0] !== 13'd0 || load_q[ld0+1] !== 13'd4) begin
      n_bad++; $display("FAIL basic_loads: got %0d loads want 2 at 0,4", load_q.size() - ld0); end
    n_vec++; if (store_q.size() - st0 != 2 || store_q[st0] !== 13'd16 || store_q[st0+1] !== 13'd20) begin
      n_bad++; $display("FAIL basic_stores: got %0d stores want 2 at 16,20", store_q.size() - st0); end
    n_vec++; if (done_cnt - dn0 != 1) begin
      n_bad++; $display("FAIL basic_donecnt: got %0d want 1", done_cnt - dn0); end
  endtask

  task automatic test_range();
    int ld0 = load_q.size();
    in_base = 13'd60; out_base = 13'd0; num_tiles = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (err !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL range_in: got err=%b busy=%b want 1/0", err, busy); end
    in_base = 13'd0; out_base = 13'd61; num_tiles = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (err !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL range_out: got err=%b busy=%b want 1/0", err, busy); end
    repeat (2) tick();
    n_vec++; if (load_q.size() != ld0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL range_nostrobe: got %0d loads busy=%b want 0/0", load_q.size() - ld0, busy); end
    // Exactly at the buffer end is legal.
    in_base = 13'd56; out_base = 13'd56; num_tiles = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (err !== 1'b0 || ub_load_input !== 1'b1 || ub_addr !== 13'd56) begin
      n_bad++; $display("FAIL range_edge: got err=%b load=%b addr=%0d want 0/1/56", err, ub_load_input, ub_addr); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_zero_tiles();
    int ld0 = load_q.size();
    int st0 = store_q.size();
    in_base = 13'd63; out_base = 13'd0; num_tiles = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (done !== 1'b1 || ub_load_input !== 1'b0 || ub_store !== 1'b0) begin
      n_bad++; $display("FAIL zero_done: got done=%b ld=%b st=%b want 1/0/0", done, ub_load_input, ub_store); end
    tick();
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_end: got done=%b busy=%b want 0/0", done, busy); end
    n_vec++; if (load_q.size() != ld0 || store_q.size() != st0) begin
      n_bad++; $display("FAIL zero_nostrobe: got %0d/%0d want 0/0", load_q.size() - ld0, store_q.size() - st0); end
  endtask

  task automatic test_one_flag();
    int early = 0;
    in_base = 13'd8; out_base = 13'd32; num_tiles = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    acc1_full = 1'b1;
    repeat (10) begin
      tick();
      if (ub_store !== 1'b0 || busy !== 1'b1) early++;
    end
    n_vec++; if (early != 0) begin n_bad++; $display("FAIL oneflag_hold: got %0d bad cycles want 0", early); end
    acc1_full = 1'b0; acc2_full = 1'b1;
    tick();
    n_vec++; if (ub_store !== 1'b0) begin n_bad++; $display("FAIL oneflag_acc2: got st=%b want 0", ub_store); end
    acc1_full = 1'b1;
    tick();
    acc1_full = 1'b0; acc2_full = 1'b0;
    n_vec++; if (ub_store !== 1'b1 || ub_addr !== 13'd32) begin
      n_bad++; $display("FAIL oneflag_store: got st=%b addr=%0d want 1/32", ub_store, ub_addr); end
    tick();
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL oneflag_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_timeout();
    int ld0 = load_q.size();
    int dn0 = done_cnt;
    in_base = 13'd0; out_base = 13'd0; num_tiles = 4'd3; start = 1'b1;
    tick();
    in_base = 13'd40; num_tiles = 4'd5;
    tick();
    for (int i = 0; i < 254; i++) begin
      if (i == 2) start = 1'b0;
      tick();
    end
    n_vec++; if (busy !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_early: got busy=%b err=%b want 1/0", busy, err); end
    tick();
    n_vec++; if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL tmo_fire: got busy=%b err=%b done=%b want 0/1/0", busy, err, done); end
    n_vec++; if (load_q.size() - ld0 != 1 || load_q[ld0] !== 13'd0 || done_cnt != dn0) begin
      n_bad++; $display("FAIL tmo_ignore: got %0d loads %0d dones want 1/0", load_q.size() - ld0, done_cnt - dn0); end
    // Abort outranks a valid start and leaves err alone.
    in_base = 13'd0; num_tiles = 4'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_vec++; if (busy !== 1'b0 || err !== 1'b1 || ub_load_input !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got busy=%b err=%b ld=%b want 0/1/0", busy, err, ub_load_input); end
    tick();
  endtask

  task automatic test_back_to_back();
    int ld0 = load_q.size();
    int st0 = store_q.size();
    in_base = 13'd4; out_base = 13'd8; num_tiles = 4'd2; start = 1'b1;
    acc1_full = 1'b1; acc2_full = 1'b1;
    tick();
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_errclr: got %b want 0", err); end
    in_base = 13'd20; out_base = 13'd30; num_tiles = 4'd7;
    repeat (4) tick();
    start = 1'b0;
    repeat (2) tick();
    n_vec++; if (done !== 1'b1 || tile_idx !== 4'd1) begin
      n_bad++; $display("FAIL b2b_done: got done=%b tile=%0d want 1/1", done, tile_idx); end
    acc1_full = 1'b0; acc2_full = 1'b0;
    tick();
    n_vec++; if (load_q.size() - ld0 != 2 || load_q[ld0] !== 13'd4 || load_q[ld0+1] !== 13'd8) begin
      n_bad++; $display("FAIL b2b_loads: got %0d loads want 4,8", load_q.size() - ld0); end
    n_vec++; if (store_q.size() - st0 != 2 || store_q[st0] !== 13'd8 || store_q[st0+1] !== 13'd12) begin
      n_bad++; $display("FAIL b2b_stores: got %0d stores want 8,12", store_q.size() - st0); end
  endtask

  task automatic test_abort_reset();
    int ld0 = load_q.size();
    int st0 = store_q.size();
    int dn0 = done_cnt;
    in_base = 13'd12; out_base = 13'd0; num_tiles = 4'd2; start = 1'b1;
    tick();
    n_vec++; if (ub_load_input !== 1'b1 || ub_addr !== 13'd12) begin
      n_bad++; $display("FAIL abort_load: got ld=%b addr=%0d want 1/12", ub_load_input, ub_addr); end
    abort = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    n_vec++; if (busy !== 1'b0 || ub_load_input !== 1'b0 || ub_store !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle2: got busy=%b ld=%b st=%b want 0/0/0", busy, ub_load_input, ub_store); end
    repeat (2) tick();
    in_base = 13'd0; out_base = 13'd4; num_tiles = 4'd1; start = 1'b1;
    acc1_full = 1'b1; acc2_full = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    n_vec++; if (ub_store !== 1'b1 || ub_addr !== 13'd4) begin
      n_bad++; $display("FAIL rstjob_store: got st=%b addr=%0d want 1/4", ub_store, ub_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0; acc1_full = 1'b0; acc2_full = 1'b0;
    n_vec++; if (ub_addr !== 13'd0 || ub_store !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                 err !== 1'b0 || tile_idx !== 4'd0 || ub_load_input !== 1'b0) begin
      n_bad++; $display("FAIL rstjob_outs: got addr=%0d st=%b busy=%b done=%b err=%b tile=%0d want all 0",
                        ub_addr, ub_store, busy, done, err, tile_idx); end
    repeat (3) tick();
    n_vec++; if (load_q.size() - ld0 != 2 || store_q.size() - st0 != 1 || done_cnt != dn0) begin
      n_bad++; $display("FAIL rstjob_log: got ld=%0d st=%0d done=%0d want 2/1/0",
                        load_q.size() - ld0, store_q.size() - st0, done_cnt - dn0); end
  endtask

  initial begin
    test_reset();
    test_two_tiles();
    test_range();
    test_zero_tiles();
    test_one_flag();
    test_timeout();
    test_back_to_back();
    test_abort_reset();
    n_vec++; if (overlap_cnt != 0) begin
      n_bad++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
